// File: rtl/tt_bin_clock_pkg.sv
// Shared types and default timing for the binary clock input path.
package tt_bin_clock_pkg;

  // Button channel states; the fourth code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Default timing at the 100 Hz core clock.
  localparam int DEBOUNCE_CYC_DEF = 2;   // 20 ms
  localparam int REPEAT_DELAY_DEF = 50;  // 0.5 s before auto-repeat
  localparam int REPEAT_RATE_DEF  = 10;  // 0.1 s between repeats

  // Larger of two integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
module tt_btn_debounce
  import tt_bin_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the raw pad level into the clk_i domain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; flip the level once the run is long enough.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounced level and run counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/tt_bin_clock_btn_cond.sv
// Input conditioning for the binary clock core: clean switch levels and
// single-cycle step pulses with hold-to-auto-repeat for the three buttons.
module tt_bin_clock_btn_cond
  import tt_bin_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic time_set_raw,
  input  logic id_switch_raw,
  input  logic hour_btn_raw,
  input  logic minute_btn_raw,
  input  logic seconds_btn_raw,
  output logic time_set,
  output logic id_switch,
  output logic hour_id,
  output logic minute_id,
  output logic seconds_id
);

  localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  // Bit 0 set-mode, bit 1 inc/dec, bits 2..4 hour/minute/seconds buttons.
  logic [4:0] raw_vec;
  logic [4:0] db_vec;
  logic [2:0] pulse_vec;
  logic       time_set_q, id_switch_q;

  assign raw_vec = {seconds_btn_raw, minute_btn_raw, hour_btn_raw, id_switch_raw, time_set_raw};

  for (genvar i = 0; i < 5; i++) begin : g_db
    tt_btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .raw_i  (raw_vec[i]),
      .db     (db_vec[i])
    );
  end

  // Registered switch levels so the core sees flop outputs only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      time_set_q  <= 1'b0;
      id_switch_q <= 1'b0;
    end else begin
      time_set_q  <= db_vec[0];
      id_switch_q <= db_vec[1];
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_state_e        state_q, state_d;
    logic [RCNT_W-1:0] cnt_q, cnt_d;
    logic              prev_q;
    logic              pulse_q, pulse_d;
    logic              btn_db;

    assign btn_db = db_vec[b + 2];

    // Next state: fire on a qualified press edge, then after the delay, then at the repeat rate.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!btn_db || !db_vec[0]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            // Only a fresh press counts; a button already held when set-mode rises is ignored.
            if (!prev_q) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
              state_d = DELAY;
            end
          end
          DELAY: begin
            if (cnt_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
              state_d = REPEAT;
            end else begin
              cnt_d = cnt_q + RCNT_W'(1);
            end
          end
          REPEAT: begin
            if (cnt_q == RATE_LAST) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + RCNT_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Channel state, repeat counter, press-edge history and pulse register.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        prev_q  <= btn_db;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_vec[b] = pulse_q;
  end

  assign time_set   = time_set_q;
  assign id_switch  = id_switch_q;
  assign hour_id    = pulse_vec[0];
  assign minute_id  = pulse_vec[1];
  assign seconds_id = pulse_vec[2];

endmodule

// File: doc/tt_bin_clock_btn_cond.md
Name: tt_bin_clock_btn_cond

Overview:
Input-conditioning stage directly upstream of the binary clock core. It takes raw pad inputs: the set-mode switch, the inc/dec switch, and three push-buttons.
- Each input is synchronised and debounced.
- The two switches are delivered to the core as clean levels.
- The three buttons are delivered as single-cycle pulses with hold-to-auto-repeat, so one press moves a time field by exactly one step.
- Runs on the same 100 Hz clk_i as the core.

Parameters:
DEBOUNCE_CYC, 2, consecutive synchronised cycles an input must differ from its debounced level before that level changes (20 ms at 100 Hz).
REPEAT_DELAY, 50, cycles a button is held after its first pulse before auto-repeat starts (0.5 s).
REPEAT_RATE, 10, cycles between auto-repeat pulses (0.1 s).

Ports:
clk_i  input  1  system clock, 100 Hz
reset_i  input  1  reset, asynchronous, active-high
time_set_raw  input  1  raw set-mode switch, asynchronous to clk_i
id_switch_raw  input  1  raw increment(1)/decrement(0) switch
hour_btn_raw  input  1  raw hour push-button, active-high
minute_btn_raw  input  1  raw minute push-button, active-high
seconds_btn_raw  input  1  raw seconds push-button, active-high
time_set  output  1  debounced set-mode level
id_switch  output  1  debounced inc/dec level
hour_id  output  1  hour step pulse, 1 cycle wide
minute_id  output  1  minute step pulse, 1 cycle wide
seconds_id  output  1  seconds step pulse, 1 cycle wide

Behaviour:
- Reset: reset is clk_i/reset_i as already decided (reset_i asynchronous, active-high). While reset_i is high, all synchroniser flops, debounced levels, counters and outputs are 0, and every FSM is in IDLE. Reset mid-press: the press is discarded, and the button must be debounced afresh after release of reset.
- Synchroniser: 2-flop chain per input.
- Debounce, per input:
  - Counter clears whenever the synchronised value equals the debounced level db.
  - Counter increments each cycle they differ.
  - db toggles on the DEBOUNCE_CYC-th consecutive differing cycle, and the counter then clears.
  - Latency: raw change first sampled at edge 0 → db changes after edge DEBOUNCE_CYC+1 (edge 3 at default).
  - Glitches shorter than DEBOUNCE_CYC synchronised cycles never change db.
- time_set and id_switch outputs: registered copies of their db levels, adding 1 cycle (visible after edge DEBOUNCE_CYC+2).
- Button FSM, one per button; states IDLE, DELAY, REPEAT; repeat counter of width $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
  - IDLE: on db 0→1 while time_set db = 1 → pulse for 1 cycle, counter = 0, go to DELAY.
  - DELAY: counter increments each cycle. On the REPEAT_DELAY-th cycle after the first pulse → pulse, counter = 0, go to REPEAT.
  - REPEAT: pulse every REPEAT_RATE cycles.
  - Any state: db = 0 → IDLE at the next edge, no pulse, counter = 0.
  - Any state: time_set db = 0 → IDLE at the next edge, no pulse.
- Pulse timing: registered, asserted during the cycle after the edge at which db rose.
- time_set rising while a button is already held → no pulse until that button is released and pressed again (rising-edge only, no level trigger).
- id_switch changes do not affect FSMs; the core samples id_switch together with the pulse.
- Simultaneous buttons: channels are fully independent; several pulses may assert in the same cycle. Priority resolution belongs to the core.
- Outputs are glitch-free: driven directly from flops.

Decomposition:
- Shared package tt_bin_clock_pkg:
  - FSM state encoding: IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - Defaults DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_RATE as localparams for the clock top.
- Sub-module tt_btn_debounce: synchroniser plus debounce for one input, parameter DEBOUNCE_CYC, output db.
  - Instantiated 5 times.
  - The 3 button FSMs live in the top level, generated by a loop.

Test Plan:
1. Reset 3 cycles, then idle → all five outputs 0; assert reset_i mid-hold → outputs go to 0 immediately (asynchronously), with no pulse after release.
2. time_set_raw high held → time_set rises after edge 4 (DEBOUNCE_CYC=2); 1-cycle 0 glitch on time_set_raw → time_set stays 1.
3. time_set = 1; seconds_btn_raw high for 20 cycles, then low → exactly one seconds_id pulse, 1 cycle wide, after edge 4; no other pulses.
4. time_set = 1; hour_btn_raw held 120 cycles → pulses at t0, t0+50, t0+60, t0+70, t0+80, t0+90, t0+100, t0+110 (8 total); none after release.
5. hour_btn_raw held, then time_set_raw raised → no hour_id pulse; release and re-press → 1 pulse.
6. time_set = 1; minute and seconds buttons pressed in the same cycle → minute_id and seconds_id pulse in the same cycle; id_switch toggled during hold → pulse timing unchanged.
